// File: rtl/sevenseg_scan_pkg.sv
// Shared definitions for the seven-segment scanner: character codes,
// the active-low segment table and the display-set record.
package sevenseg_pkg;

  localparam logic [3:0] CH_B     = 4'hA;
  localparam logic [3:0] CH_C     = 4'hB;
  localparam logic [3:0] CH_P     = 4'hC;
  localparam logic [3:0] CH_E     = 4'hD;
  localparam logic [3:0] CH_DASH  = 4'hE;
  localparam logic [3:0] CH_BLANK = 4'hF;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Indexed directly by character code; bit 0 is segment a, bit 6 is g.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1111111,  // F blank
    7'b0111111,  // E dash
    7'b0000110,  // D E
    7'b0001100,  // C P
    7'b1000110,  // B C
    7'b0000011,  // A b
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef struct packed {
    logic [31:0] chars;
    logic [7:0]  blank_mask;
    logic [7:0]  blink_mask;
  } disp_set_t;

  localparam disp_set_t DISP_RESET = '{
    chars:      32'hFFFF_FFFF,
    blank_mask: 8'h00,
    blink_mask: 8'h00
  };

endpackage

// File: rtl/sevenseg_scan_if.sv
// Connection between the game FSM (master) and the display scanner (slave).
interface sevenseg_scan_if;

  logic        load;
  logic [31:0] chars;
  logic [7:0]  blank_mask;
  logic [7:0]  blink_mask;
  logic [7:0]  an;
  logic [6:0]  digit;
  logic        frame_done;

  modport master (
    output load, chars, blank_mask, blink_mask,
    input  an, digit, frame_done
  );

  modport slave (
    input  load, chars, blank_mask, blink_mask,
    output an, digit, frame_done
  );

endinterface

// File: rtl/sevenseg_scan_decode.sv
// Combinational character-code to active-low segment pattern lookup.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[code];
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Eight-digit multiplexed seven-segment driver with frame-synchronous
// double buffering, per-digit blanking/blinking and a dead band per slot.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int DEAD        = 4,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  logic            clock,
  input  logic            reset,
  sevenseg_scan_if.slave  bus
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] DEAD_CNT   = DIV_W'(DEAD);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [2:0]       idx;
  logic [BLK_W-1:0] bcnt;
  logic             bphase;

  disp_set_t shadow;
  disp_set_t active;
  logic      pending;

  logic slot_end;
  logic frame_wrap;

  logic [3:0] cur_code;
  logic       cur_dark;
  logic [6:0] cur_seg;

  logic [7:0] an_next;
  logic [6:0] digit_next;

  logic [7:0] an_q;
  logic [6:0] digit_q;
  logic       frame_done_q;

  assign slot_end   = (div == DIV_LAST);
  assign frame_wrap = slot_end && (idx == 3'd7);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div <= '0;
      idx <= '0;
    end else if (slot_end) begin
      div <= '0;
      idx <= idx + 3'd1;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bcnt   <= '0;
      bphase <= 1'b0;
    end else if (bcnt == BLINK_LAST) begin
      bcnt   <= '0;
      bphase <= ~bphase;
    end else begin
      bcnt <= bcnt + BLK_W'(1);
    end
  end

  // The wrap consumes whatever was pending before this edge; a load on the
  // same edge re-arms pending so it lands one frame later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow  <= DISP_RESET;
      active  <= DISP_RESET;
      pending <= 1'b0;
    end else begin
      if (frame_wrap && pending) begin
        active <= shadow;
      end
      if (bus.load) begin
        shadow  <= '{chars:      bus.chars,
                     blank_mask: bus.blank_mask,
                     blink_mask: bus.blink_mask};
        pending <= 1'b1;
      end else if (frame_wrap) begin
        pending <= 1'b0;
      end
    end
  end

  assign cur_code = active.chars[{idx, 2'b00} +: 4];
  assign cur_dark = active.blank_mask[idx]
                  | (active.blink_mask[idx] & bphase)
                  | (cur_code == CH_BLANK);

  sevenseg_decode u_decode (
    .code (cur_code),
    .seg  (cur_seg)
  );

  always_comb begin
    an_next    = 8'hFF;
    digit_next = SEG_BLANK;
    if (div >= DEAD_CNT) begin
      an_next = ~(8'd1 << idx);
      if (!cur_dark) begin
        digit_next = cur_seg;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an_q         <= 8'hFF;
      digit_q      <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      an_q         <= an_next;
      digit_q      <= digit_next;
      frame_done_q <= frame_wrap;
    end
  end

  assign bus.an         = an_q;
  assign bus.digit      = digit_q;
  assign bus.frame_done = frame_done_q;

  // At most one anode may ever be enabled.
  assert property (@(posedge clock) disable iff (reset) $countones(~an_q) <= 1);

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan: a time-based reference model predicts
// each registered output and a monitor compares them one cycle later.
module tb_sevenseg_scan;

  localparam int RD    = 4;
  localparam int DEADC = 1;
  localparam int BD    = 64;
  localparam int FRAME = 8 * RD;

  logic clock;
  logic reset;

  sevenseg_scan_if bus ();

  sevenseg_scan #(
    .REFRESH_DIV (RD),
    .DEAD        (DEADC),
    .BLINK_DIV   (BD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int unsigned t;
    logic [7:0]  an;
    logic [6:0]  digit;
    logic        fd;
  } exp_t;

  exp_t expq[$];

  int checks = 0;
  int errors = 0;

  logic [6:0] segRef [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0000011, 7'b1000110,
    7'b0001100, 7'b0000110, 7'b0111111, 7'b1111111
  };

  // Reference model: s counts clock edges since reset release.
  int unsigned s;
  logic [31:0] modelChars, shadowChars;
  logic [7:0]  modelBlank, shadowBlank;
  logic [7:0]  modelBlink, shadowBlink;
  logic        modelPending;

  function automatic void modelReset();
    s            = 0;
    modelChars   = 32'hFFFF_FFFF;
    shadowChars  = 32'hFFFF_FFFF;
    modelBlank   = 8'h00;
    shadowBlank  = 8'h00;
    modelBlink   = 8'h00;
    shadowBlink  = 8'h00;
    modelPending = 1'b0;
  endfunction

  function automatic exp_t modelOutput(int unsigned t);
    exp_t        e;
    int unsigned slotPos  = t % RD;
    int unsigned digitNo  = (t / RD) % 8;
    logic        blinkOn  = ((t / BD) % 2) == 1;
    logic [3:0]  code     = modelChars[digitNo*4 +: 4];
    logic        darkened;
    e.t  = t;
    e.fd = (t % FRAME) == FRAME - 1;
    if (slotPos < DEADC) begin
      e.an    = 8'hFF;
      e.digit = 7'h7F;
    end else begin
      e.an     = ~(8'd1 << digitNo);
      darkened = modelBlank[digitNo] || (modelBlink[digitNo] && blinkOn) || (code == 4'hF);
      e.digit  = darkened ? 7'h7F : segRef[code];
    end
    return e;
  endfunction

  function automatic void modelStep(logic ld, logic [31:0] ch, logic [7:0] bm, logic [7:0] km);
    if ((s % FRAME) == FRAME - 1) begin
      if (modelPending) begin
        modelChars = shadowChars;
        modelBlank = shadowBlank;
        modelBlink = shadowBlink;
      end
      modelPending = 1'b0;
    end
    if (ld) begin
      shadowChars  = ch;
      shadowBlank  = bm;
      shadowBlink  = km;
      modelPending = 1'b1;
    end
    s++;
  endfunction

  task automatic applyStimulus(input logic ld, input logic [31:0] ch,
                               input logic [7:0] bm, input logic [7:0] km);
    @(negedge clock);
    bus.load       = ld;
    bus.chars      = ch;
    bus.blank_mask = bm;
    bus.blink_mask = km;
    expq.push_back(modelOutput(s));
    modelStep(ld, ch, bm, km);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (bus.an !== e.an || bus.digit !== e.digit || bus.frame_done !== e.fd) begin
      errors++;
      $display("[TB] FAIL scan t=%0d an got %h want %h, digit got %b want %b, frame_done got %b want %b",
               e.t, bus.an, e.an, bus.digit, e.digit, bus.frame_done, e.fd);
    end
  endtask

  task automatic checkReset(input string tag);
    checks++;
    if (bus.an !== 8'hFF || bus.digit !== 7'h7F || bus.frame_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s an got %h want ff, digit got %b want 1111111, frame_done got %b want 0",
               tag, bus.an, bus.digit, bus.frame_done);
    end
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, $urandom, 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic runUntilPos(input int unsigned pos);
    for (int i = 0; i < FRAME && (s % FRAME) != pos; i++) begin
      applyStimulus(1'b0, $urandom, 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic drainQueue();
    for (int i = 0; i < 10 && expq.size() != 0; i++) begin
      @(posedge clock);
      #3;
    end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain queue left %0d want 0", expq.size());
      expq.delete();
    end
  endtask

  always begin
    @(posedge clock);
    #1;
    if (expq.size() > 0) begin
      checkOutput(expq.pop_front());
    end
  end

  initial begin
    reset          = 1'b1;
    bus.load       = 1'b0;
    bus.chars      = 32'h0;
    bus.blank_mask = 8'h00;
    bus.blink_mask = 8'h00;
    modelReset();
    repeat (3) @(posedge clock);
    #1;
    checkReset("reset_values");
    @(posedge clock);
    #2;
    reset = 1'b0;

    $display("[TB] idle scan");
    runIdle(64);

    $display("[TB] single load mid-frame");
    runUntilPos(9);
    applyStimulus(1'b1, 32'h0123_4567, 8'h00, 8'h00);
    runIdle(2 * FRAME);

    $display("[TB] two loads in one frame");
    runUntilPos(3);
    applyStimulus(1'b1, 32'h1111_1111, 8'h00, 8'h00);
    runIdle(5);
    applyStimulus(1'b1, 32'h2222_2222, 8'h00, 8'h00);
    runIdle(2 * FRAME);

    $display("[TB] load on frame wrap");
    runUntilPos(FRAME - 1);
    applyStimulus(1'b1, 32'h89AB_CDE0, 8'h00, 8'h00);
    runIdle(3 * FRAME);

    $display("[TB] blink digit 0");
    applyStimulus(1'b1, 32'h3456_789A, 8'h00, 8'h01);
    runIdle(5 * BD);

    $display("[TB] random loads");
    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom_range(0, 15) == 0, $urandom,
                    ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                    ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
    end

    $display("[TB] reset with load pending");
    runUntilPos(4);
    applyStimulus(1'b1, 32'h1234_5678, 8'h00, 8'h00);
    applyStimulus(1'b0, 32'h0, 8'h00, 8'h00);
    drainQueue();
    reset = 1'b1;
    #1;
    checkReset("async_reset");
    repeat (2) @(posedge clock);
    #1;
    checkReset("held_reset");
    @(posedge clock);
    #2;
    reset = 1'b0;
    modelReset();
    runIdle(3 * FRAME);

    drainQueue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
